// File: rtl/mem_port_ctrl_pkg.sv
// Shared definitions for the memory port sequencer: FSM state encoding and
// the width rule for the wait-cycle counter.
package mem_port_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RD_WAIT = 2'd1,
      ST_WR_WAIT = 2'd2,
      ST_DONE    = 2'd3
   } state_e;

   // Wide enough to hold the larger latency minus one without wrapping.
   function automatic int cnt_width(input int rd_lat, input int wr_lat);
      int max_lat;
      max_lat = (rd_lat > wr_lat) ? rd_lat : wr_lat;
      return $clog2(max_lat) + 1;
   endfunction

endpackage

// File: rtl/mem_lat_counter.sv
// Down-counter timing the wait phase of a memory access; loaded on accept,
// decremented while waiting, saturating at zero.
module mem_lat_counter #(
   parameter int CNT_W = 2
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             load_i,
   input  logic             dec_i,
   output logic             zero_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_port_ctrl.sv
// Memory access sequencer: accepts a read or write request in IDLE, holds the
// memory strobe for the configured latency, then pulses Done for one cycle.
module mem_port_ctrl
   import mem_port_ctrl_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int ADDR_WIDTH = 8,
   parameter int RD_LAT     = 2,
   parameter int WR_LAT     = 1
) (
   input  logic                  Clk,
   input  logic                  Rst_n,
   input  logic [ADDR_WIDTH-1:0] Addr,
   input  logic [WIDTH-1:0]      BusIn,
   input  logic                  RdReq,
   input  logic                  WrReq,
   output logic                  Busy,
   output logic                  Done,
   output logic [WIDTH-1:0]      DataOut,
   output logic [ADDR_WIDTH-1:0] MemAddr,
   output logic [WIDTH-1:0]      MemWData,
   output logic                  MemRE,
   output logic                  MemWE,
   input  logic [WIDTH-1:0]      MemRData
);

   localparam int               CNT_W   = cnt_width(RD_LAT, WR_LAT);
   localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_LAT - 1);
   localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_LAT - 1);

   state_e                state_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [WIDTH-1:0]      wdata_q;
   logic [WIDTH-1:0]      dout_q;
   logic                  busy_q;
   logic                  done_q;
   logic                  re_q;
   logic                  we_q;

   logic                  accept_d;
   logic                  cnt_load_d;
   logic                  cnt_dec_d;
   logic [CNT_W-1:0]      cnt_val_d;
   logic                  cnt_zero;

   // Write has priority when both requests arrive together.
   always_comb begin
      accept_d   = (state_q == ST_IDLE) && (RdReq || WrReq);
      cnt_load_d = accept_d;
      cnt_val_d  = WrReq ? WR_LOAD : RD_LOAD;
      cnt_dec_d  = (state_q == ST_RD_WAIT) || (state_q == ST_WR_WAIT);
   end

   mem_lat_counter #(
      .CNT_W (CNT_W)
   ) u_lat_cnt (
      .clk_i      (Clk),
      .rst_ni     (Rst_n),
      .load_val_i (cnt_val_d),
      .load_i     (cnt_load_d),
      .dec_i      (cnt_dec_d),
      .zero_o     (cnt_zero)
   );

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         dout_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         re_q    <= 1'b0;
         we_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (WrReq) begin
                  addr_q  <= Addr;
                  wdata_q <= BusIn;
                  state_q <= ST_WR_WAIT;
                  busy_q  <= 1'b1;
                  we_q    <= 1'b1;
               end else if (RdReq) begin
                  addr_q  <= Addr;
                  state_q <= ST_RD_WAIT;
                  busy_q  <= 1'b1;
                  re_q    <= 1'b1;
               end
            end
            ST_RD_WAIT: begin
               if (cnt_zero) begin
                  dout_q  <= MemRData;
                  state_q <= ST_DONE;
                  re_q    <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            ST_WR_WAIT: begin
               if (cnt_zero) begin
                  state_q <= ST_DONE;
                  we_q    <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               re_q    <= 1'b0;
               we_q    <= 1'b0;
            end
         endcase
      end
   end

   assign Busy     = busy_q;
   assign Done     = done_q;
   assign MemRE    = re_q;
   assign MemWE    = we_q;
   assign DataOut  = dout_q;
   assign MemAddr  = addr_q;
   assign MemWData = wdata_q;

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Directed bench for mem_port_ctrl against a registered RAM model (RD_LAT=2, WR_LAT=1).
module tb_mem_port_ctrl;

   logic       Clk;
   logic       Rst_n;
   logic [7:0] Addr;
   logic [7:0] BusIn;
   logic       RdReq;
   logic       WrReq;
   logic       Busy;
   logic       Done;
   logic [7:0] DataOut;
   logic [7:0] MemAddr;
   logic [7:0] MemWData;
   logic       MemRE;
   logic       MemWE;
   logic [7:0] MemRData;

   logic [7:0] ram [256];
   logic       pre_we;
   logic [7:0] pre_addr;
   logic [7:0] pre_data;

   int checks;
   int errors;

   logic [11:0] busy_vec;
   logic [11:0] done_vec;
   logic [11:0] re_vec;
   int          overlap;
   int          done_cnt;

   mem_port_ctrl #(
      .WIDTH      (8),
      .ADDR_WIDTH (8),
      .RD_LAT     (2),
      .WR_LAT     (1)
   ) dut (
      .Clk      (Clk),
      .Rst_n    (Rst_n),
      .Addr     (Addr),
      .BusIn    (BusIn),
      .RdReq    (RdReq),
      .WrReq    (WrReq),
      .Busy     (Busy),
      .Done     (Done),
      .DataOut  (DataOut),
      .MemAddr  (MemAddr),
      .MemWData (MemWData),
      .MemRE    (MemRE),
      .MemWE    (MemWE),
      .MemRData (MemRData)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Registered RAM: read data appears the cycle after MemRE is sampled.
   always @(posedge Clk) begin
      if (pre_we) ram[pre_addr] <= pre_data;
      else if (MemWE) ram[MemAddr] <= MemWData;
      if (MemRE) MemRData <= ram[MemAddr];
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic preload(input logic [7:0] a, input logic [7:0] d);
      pre_we   = 1'b1;
      pre_addr = a;
      pre_data = d;
      tick();
      pre_we   = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      Rst_n  = 1'b0;
      Addr   = 8'h00;
      BusIn  = 8'h00;
      RdReq  = 1'b0;
      WrReq  = 1'b0;
      pre_we = 1'b0;
      pre_addr = 8'h00;
      pre_data = 8'h00;
      MemRData = 8'h00;

      preload(8'h3C, 8'hA5);
      preload(8'h10, 8'h00);
      preload(8'h20, 8'h00);
      preload(8'hFF, 8'h77);

      check("rst_busy",  Busy, 0);
      check("rst_done",  Done, 0);
      check("rst_re",    MemRE, 0);
      check("rst_we",    MemWE, 0);
      check("rst_dout",  DataOut, 0);
      check("rst_maddr", MemAddr, 0);
      check("rst_mwd",   MemWData, 0);
      Rst_n = 1'b1;
      tick();
      check("idle_busy", Busy, 0);

      // 1. plain read of 3C
      Addr = 8'h3C; RdReq = 1'b1;
      tick();
      RdReq = 1'b0;
      check("rd_busy0", Busy, 1);
      check("rd_re0",   MemRE, 1);
      check("rd_addr0", MemAddr, 8'h3C);
      check("rd_done0", Done, 0);
      tick();
      check("rd_re1",   MemRE, 1);
      check("rd_done1", Done, 0);
      tick();
      check("rd_done2", Done, 1);
      check("rd_dout2", DataOut, 8'hA5);
      check("rd_re2",   MemRE, 0);
      check("rd_busy2", Busy, 1);
      tick();
      check("rd_done3", Done, 0);
      check("rd_busy3", Busy, 0);
      check("rd_dout3", DataOut, 8'hA5);

      // 2. write 5A to 10
      Addr = 8'h10; BusIn = 8'h5A; WrReq = 1'b1;
      tick();
      WrReq = 1'b0;
      check("wr_we0",   MemWE, 1);
      check("wr_re0",   MemRE, 0);
      check("wr_addr0", MemAddr, 8'h10);
      check("wr_wd0",   MemWData, 8'h5A);
      check("wr_done0", Done, 0);
      tick();
      check("wr_done1", Done, 1);
      check("wr_we1",   MemWE, 0);
      check("wr_dout1", DataOut, 8'hA5);
      tick();
      check("wr_busy2", Busy, 0);
      check("wr_ram",   ram[8'h10], 8'h5A);

      // 3. simultaneous requests: write wins
      Addr = 8'h20; BusIn = 8'hC3; RdReq = 1'b1; WrReq = 1'b1;
      tick();
      RdReq = 1'b0; WrReq = 1'b0;
      check("both_we0",   MemWE, 1);
      check("both_re0",   MemRE, 0);
      check("both_addr0", MemAddr, 8'h20);
      check("both_wd0",   MemWData, 8'hC3);
      tick();
      check("both_done1", Done, 1);
      check("both_re1",   MemRE, 0);
      tick();
      check("both_re2",   MemRE, 0);
      check("both_busy2", Busy, 0);
      Addr = 8'h20; RdReq = 1'b1;
      tick();
      RdReq = 1'b0;
      tick();
      tick();
      check("both_rdback", DataOut, 8'hC3);
      check("both_rbdone", Done, 1);
      tick();

      // 4. address change and extra request while reading
      Addr = 8'h3C; RdReq = 1'b1;
      tick();
      Addr = 8'hFF; RdReq = 1'b1;
      tick();
      RdReq = 1'b0;
      check("mid_addr1", MemAddr, 8'h3C);
      check("mid_done1", Done, 0);
      tick();
      check("mid_done2", Done, 1);
      check("mid_dout2", DataOut, 8'hA5);
      tick();
      check("mid_busy3", Busy, 0);
      check("mid_done3", Done, 0);
      tick();
      check("mid_busy4", Busy, 0);
      check("mid_done4", Done, 0);

      // 5. request held for 12 cycles
      Addr = 8'h3C; RdReq = 1'b1;
      busy_vec = '0; done_vec = '0; re_vec = '0; overlap = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         busy_vec[i] = Busy;
         done_vec[i] = Done;
         re_vec[i]   = MemRE;
         if (MemRE && MemWE) overlap++;
      end
      RdReq = 1'b0;
      check("hold_busy", busy_vec, 12'h777);
      check("hold_done", done_vec, 12'h444);
      check("hold_re",   re_vec, 12'h333);
      check("hold_ovl",  overlap, 0);
      check("hold_dout", DataOut, 8'hA5);
      tick();
      check("hold_idle", Busy, 0);

      // 6. async reset during a read
      Addr = 8'h20; RdReq = 1'b1;
      tick();
      RdReq = 1'b0;
      check("ar_re0", MemRE, 1);
      #2;
      Rst_n = 1'b0;
      #1;
      check("ar_re",    MemRE, 0);
      check("ar_busy",  Busy, 0);
      check("ar_dout",  DataOut, 0);
      check("ar_maddr", MemAddr, 0);
      tick();
      Rst_n = 1'b1;
      done_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (Done) done_cnt++;
      end
      check("ar_nodone", done_cnt, 0);
      Addr = 8'h3C; RdReq = 1'b1;
      tick();
      RdReq = 1'b0;
      check("ar_re_new", MemRE, 1);
      tick();
      tick();
      check("ar_done_new", Done, 1);
      check("ar_dout_new", DataOut, 8'hA5);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
